// File: rtl/ppu_palette_pixel_mux_if.sv
`default_nettype none
// ============================================================================
// ppu_palette_pixel_mux_if : dot, sprite-channel and CPU palette-port bundle
// Revision 1.0
// ============================================================================
interface ppu_palette_pixel_mux_if #(
  parameter int NUM_SPRITES = 8,
  parameter int COLOR_W     = 6
);
  logic                     pix_valid_in;
  logic [1:0]               bg_pixel;
  logic [1:0]               bg_palette;
  logic [2*NUM_SPRITES-1:0] spr_pixel;
  logic [2*NUM_SPRITES-1:0] spr_palette;
  logic [NUM_SPRITES-1:0]   spr_behind;
  logic                     spr0_present;
  logic                     clear_hit;
  logic                     greyscale;
  logic                     pal_we;
  logic [4:0]               pal_addr;
  logic [COLOR_W-1:0]       pal_wdata;
  logic [COLOR_W-1:0]       pal_rdata;
  logic                     pix_valid_out;
  logic [COLOR_W-1:0]       color_out;
  logic                     spr0_hit;

  modport master (
    output pix_valid_in, bg_pixel, bg_palette, spr_pixel, spr_palette, spr_behind,
    output spr0_present, clear_hit, greyscale, pal_we, pal_addr, pal_wdata,
    input  pal_rdata, pix_valid_out, color_out, spr0_hit
  );

  modport slave (
    input  pix_valid_in, bg_pixel, bg_palette, spr_pixel, spr_palette, spr_behind,
    input  spr0_present, clear_hit, greyscale, pal_we, pal_addr, pal_wdata,
    output pal_rdata, pix_valid_out, color_out, spr0_hit
  );
endinterface
`default_nettype wire

// File: rtl/ppu_palette_pixel_mux.sv
`default_nettype none
// ============================================================================
// ppu_palette_pixel_mux : BG/sprite priority mux, 32-entry palette RAM, sprite-0 hit
// Revision 1.0 -- optional greyscale masking under PPU_PALETTE_GREYSCALE_EN
// ============================================================================
module ppu_palette_pixel_mux #(
  parameter int NUM_SPRITES = 8,
  parameter int COLOR_W     = 6
) (
  input  wire logic              clk,
  input  wire logic              rst,
  ppu_palette_pixel_mux_if.slave bus
);
  localparam int PAL_DEPTH = 32;

  logic [COLOR_W-1:0] r_pal [PAL_DEPTH];
  logic               r_s1_valid;
  logic [4:0]         r_s1_addr;
  logic               r_s1_grey;
  logic               r_valid_out;
  logic [COLOR_W-1:0] r_color;
  logic [COLOR_W-1:0] r_rdata;
  logic               r_hit;

  logic               w_sp_op;
  logic               w_sp_behind;
  logic [4:0]         w_sp_addr;
  logic               w_bg_op;
  logic [4:0]         w_bg_addr;
  logic [4:0]         w_addr;
  logic               w_hit_set;
  logic [COLOR_W-1:0] w_entry;
  logic [COLOR_W-1:0] w_lookup;

  // $3F10/$14/$18/$1C alias the backdrop entries $3F00/$04/$08/$0C.
  function automatic logic [4:0] mirror(input logic [4:0] a);
    return (a[4] && (a[1:0] == 2'b00)) ? {1'b0, a[3:0]} : a;
  endfunction

  // Scan from the lowest-priority channel up so channel 0 is the last to claim the slot.
  always_comb begin
    w_sp_op     = 1'b0;
    w_sp_behind = 1'b0;
    w_sp_addr   = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (bus.spr_pixel[2*i +: 2] != 2'b00) begin
        w_sp_op     = 1'b1;
        w_sp_behind = bus.spr_behind[i];
        w_sp_addr   = {1'b1, bus.spr_palette[2*i +: 2], bus.spr_pixel[2*i +: 2]};
      end
    end
  end

  assign w_bg_op   = (bus.bg_pixel != 2'b00);
  assign w_bg_addr = {1'b0, bus.bg_palette, bus.bg_pixel};

  always_comb begin
    w_addr = '0;
    if (w_sp_op && !(w_bg_op && w_sp_behind)) begin
      w_addr = w_sp_addr;
    end else if (w_bg_op) begin
      w_addr = w_bg_addr;
    end
  end

  assign w_hit_set = bus.pix_valid_in && bus.spr0_present &&
                     (bus.spr_pixel[1:0] != 2'b00) && w_bg_op;

  assign w_entry = r_pal[mirror(r_s1_addr)];

`ifdef PPU_PALETTE_GREYSCALE_EN
  localparam logic [COLOR_W-1:0] GREY_MASK = COLOR_W'(6'h30);
  assign w_lookup = r_s1_grey ? (w_entry & GREY_MASK) : w_entry;
`else
  logic unused_s1_grey;
  assign unused_s1_grey = r_s1_grey;
  assign w_lookup       = w_entry;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_addr   <= '0;
      r_s1_grey   <= 1'b0;
      r_valid_out <= 1'b0;
      r_color     <= '0;
      r_hit       <= 1'b0;
    end else begin
      r_s1_valid  <= bus.pix_valid_in;
      if (bus.pix_valid_in) begin
        r_s1_addr <= w_addr;
        r_s1_grey <= bus.greyscale;
      end
      r_valid_out <= r_s1_valid;
      if (r_s1_valid) begin
        r_color <= w_lookup;
      end
      if (w_hit_set) begin
        r_hit <= 1'b1;
      end else if (bus.clear_hit) begin
        r_hit <= 1'b0;
      end
    end
  end

  // Reads sample the array before this edge's write lands (read-before-write).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PAL_DEPTH; i++) begin
        r_pal[i] <= '0;
      end
      r_rdata <= '0;
    end else begin
      if (bus.pal_we) begin
        r_pal[mirror(bus.pal_addr)] <= bus.pal_wdata;
      end
      r_rdata <= r_pal[mirror(bus.pal_addr)];
    end
  end

  assign bus.pal_rdata     = r_rdata;
  assign bus.pix_valid_out = r_valid_out;
  assign bus.color_out     = r_color;
  assign bus.spr0_hit      = r_hit;

endmodule
`default_nettype wire
